// File: rtl/result_frame_scanout.sv
// result_frame_scanout: pixel write port into a dual-port frame buffer, scanned out as a VGA raster.
// Outputs lag the raster counters by 2 clocks; RESULT_FRAME_CLEAR_EN adds an iClear-driven zeroing sweep.
module result_frame_scanout #(
  parameter int WIDTH_BITS  = 8,
  parameter int HEIGHT_BITS = 8,
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33
) (
  input  logic                   clock,
  input  logic                   not_reset,
  input  logic                   iPixEn,
  input  logic [WIDTH_BITS-1:0]  iX,
  input  logic [HEIGHT_BITS-1:0] iY,
  input  logic [2:0]             iR,
  input  logic [2:0]             iG,
  input  logic [2:0]             iB,
  input  logic                   iWren,
  input  logic                   iClear,
  output logic                   oClearBusy,
  output logic                   oHSync,
  output logic                   oVSync,
  output logic [2:0]             oR,
  output logic [2:0]             oG,
  output logic [2:0]             oB,
  output logic                   oActive,
  output logic                   oFrameStart
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HC_W    = $clog2(H_TOTAL);
  localparam int VC_W    = $clog2(V_TOTAL);
  localparam int AW      = WIDTH_BITS + HEIGHT_BITS;
  localparam int DEPTH   = 1 << AW;

  localparam logic [HC_W-1:0] H_MAX     = HC_W'(H_TOTAL - 1);
  localparam logic [HC_W-1:0] H_ACT     = HC_W'(H_ACTIVE);
  localparam logic [HC_W-1:0] H_SYNC_LO = HC_W'(H_ACTIVE + H_FP);
  localparam logic [HC_W-1:0] H_SYNC_HI = HC_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HC_W-1:0] H_IMG     = HC_W'(1 << WIDTH_BITS);
  localparam logic [VC_W-1:0] V_MAX     = VC_W'(V_TOTAL - 1);
  localparam logic [VC_W-1:0] V_ACT     = VC_W'(V_ACTIVE);
  localparam logic [VC_W-1:0] V_SYNC_LO = VC_W'(V_ACTIVE + V_FP);
  localparam logic [VC_W-1:0] V_SYNC_HI = VC_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VC_W-1:0] V_IMG     = VC_W'(1 << HEIGHT_BITS);

  logic [HC_W-1:0] hcnt;
  logic [VC_W-1:0] vcnt;
  logic            hs_n0, vs_n0, act0, vis0, fs0;
  logic [AW-1:0]   rd_addr;
  logic [8:0]      rd_dat;
  logic            hs_n1, vs_n1, act1, vis1, fs1;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [8:0]      wr_dat;
  logic [8:0]      mem [DEPTH];

  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (iPixEn) begin
      if (hcnt == H_MAX) begin
        hcnt <= '0;
        vcnt <= (vcnt == V_MAX) ? '0 : vcnt + VC_W'(1);
      end else begin
        hcnt <= hcnt + HC_W'(1);
      end
    end
  end

  always_comb begin
    hs_n0   = !((hcnt >= H_SYNC_LO) && (hcnt < H_SYNC_HI));
    vs_n0   = !((vcnt >= V_SYNC_LO) && (vcnt < V_SYNC_HI));
    act0    = (hcnt < H_ACT) && (vcnt < V_ACT);
    vis0    = act0 && (hcnt < H_IMG) && (vcnt < V_IMG);
    // Qualified by iPixEn so a frozen raster at (0,0) does not repeat the pulse.
    fs0     = iPixEn && (hcnt == '0) && (vcnt == '0);
    rd_addr = {vcnt[HEIGHT_BITS-1:0], hcnt[WIDTH_BITS-1:0]};
  end

  // Read-before-write: a same-address collision returns the old word.
  always_ff @(posedge clock) begin
    if (wr_en)
      mem[wr_addr] <= wr_dat;
    rd_dat <= mem[rd_addr];
  end

  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) begin
      hs_n1       <= 1'b1;
      vs_n1       <= 1'b1;
      act1        <= 1'b0;
      vis1        <= 1'b0;
      fs1         <= 1'b0;
      oHSync      <= 1'b1;
      oVSync      <= 1'b1;
      oActive     <= 1'b0;
      oFrameStart <= 1'b0;
      {oR, oG, oB} <= '0;
    end else begin
      hs_n1       <= hs_n0;
      vs_n1       <= vs_n0;
      act1        <= act0;
      vis1        <= vis0;
      fs1         <= fs0;
      oHSync      <= hs_n1;
      oVSync      <= vs_n1;
      oActive     <= act1;
      oFrameStart <= fs1;
      {oR, oG, oB} <= vis1 ? rd_dat : 9'd0;
    end
  end

`ifdef RESULT_FRAME_CLEAR_EN
  typedef enum logic {CLR_IDLE, CLR_SWEEP} clr_state_t;
  clr_state_t    clr_state, clr_state_nxt;
  logic [AW-1:0] clr_addr;

  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) begin
      clr_state <= CLR_IDLE;
      clr_addr  <= '0;
    end else begin
      clr_state <= clr_state_nxt;
      clr_addr  <= (clr_state == CLR_SWEEP) ? clr_addr + AW'(1) : '0;
    end
  end

  // The sweep owns the write port; external writes are dropped while it runs.
  always_comb begin
    clr_state_nxt = clr_state;
    wr_en         = iWren;
    wr_addr       = {iY, iX};
    wr_dat        = {iR, iG, iB};
    case (clr_state)
      CLR_IDLE: if (iClear) clr_state_nxt = CLR_SWEEP;
      CLR_SWEEP: begin
        wr_en   = 1'b1;
        wr_addr = clr_addr;
        wr_dat  = '0;
        if (clr_addr == '1) clr_state_nxt = CLR_IDLE;
      end
      default: clr_state_nxt = CLR_IDLE;
    endcase
  end

  assign oClearBusy = (clr_state == CLR_SWEEP);
`else
  logic unused_clear;
  assign unused_clear = iClear;
  assign wr_en        = iWren;
  assign wr_addr      = {iY, iX};
  assign wr_dat       = {iR, iG, iB};
  assign oClearBusy   = 1'b0;
`endif

endmodule

// File: tb/tb_result_frame_scanout.sv
// Directed bench for result_frame_scanout on a shrunken 56x27 raster with a 16x8 image.
// Expected values are hand-derived: output after edge t shows the raster position held after edge t-2.
module tb_result_frame_scanout;
  localparam int WB = 4;
  localparam int HB = 3;
`ifdef RESULT_FRAME_CLEAR_EN
  localparam int CLR = 1;
`else
  localparam int CLR = 0;
`endif
  localparam int FILL = (CLR != 0) ? 0 : 511;

  logic          clock = 1'b0;
  logic          not_reset = 1'b0;
  logic          iPixEn = 1'b0;
  logic [WB-1:0] iX = '0;
  logic [HB-1:0] iY = '0;
  logic [2:0]    iR = '0, iG = '0, iB = '0;
  logic          iWren = 1'b0;
  logic          iClear = 1'b0;
  logic          oClearBusy, oHSync, oVSync, oActive, oFrameStart;
  logic [2:0]    oR, oG, oB;

  int n_checks = 0;
  int n_errors = 0;

  result_frame_scanout #(
    .WIDTH_BITS(WB), .HEIGHT_BITS(HB),
    .H_ACTIVE(40), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(20), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dut (
    .clock(clock), .not_reset(not_reset), .iPixEn(iPixEn),
    .iX(iX), .iY(iY), .iR(iR), .iG(iG), .iB(iB),
    .iWren(iWren), .iClear(iClear), .oClearBusy(oClearBusy),
    .oHSync(oHSync), .oVSync(oVSync), .oR(oR), .oG(oG), .oB(oB),
    .oActive(oActive), .oFrameStart(oFrameStart)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got %0d want %0d", tag, got, want);
    end
  endtask

  function automatic logic [31:0] px();
    return 32'({oR, oG, oB});
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input int x, input int y, input logic [8:0] c);
    iX = WB'(x);
    iY = HB'(y);
    {iR, iG, iB} = c;
    iWren = 1'b1;
    tick();
    iWren = 1'b0;
  endtask

  initial begin
    int hs_f1, hs_f2, hs_cnt, vs_cnt, act_cnt, fs_cnt, fs1, fs2, busy_cnt;
    logic prev_hs;

    #12;
    check("rst_hsync", 32'(oHSync), 1);
    check("rst_vsync", 32'(oVSync), 1);
    check("rst_rgb", px(), 0);
    check("rst_active", 32'(oActive), 0);
    check("rst_fstart", 32'(oFrameStart), 0);
    check("rst_busy", 32'(oClearBusy), 0);

    tick();
    not_reset = 1'b1;
    for (int a = 0; a < 128; a++) wr(a % 16, a / 16, 9'd0);
    wr(5, 3, 9'o777);
    wr(15, 7, 9'o777);
    wr(0, 7, 9'o777);
    wr(2, 7, 9'o124);
    wr(8, 2, 9'o070);

    // Full-rate frame; (8,2) is rewritten on the very edge that reads it.
    hs_f1 = -1; hs_f2 = -1; hs_cnt = 0; vs_cnt = 0; act_cnt = 0;
    fs_cnt = 0; fs1 = -1; fs2 = -1;
    iPixEn = 1'b1;
    prev_hs = oHSync;
    for (int t = 1; t <= 1640; t++) begin
      if (t == 121) begin
        iX = 4'd8; iY = 3'd2; {iR, iG, iB} = 9'o777; iWren = 1'b1;
      end else begin
        iWren = 1'b0;
      end
      tick();
      if (prev_hs && !oHSync) begin
        if (hs_f1 < 0) hs_f1 = t;
        else if (hs_f2 < 0) hs_f2 = t;
      end
      prev_hs = oHSync;
      if (t <= 58 && !oHSync) hs_cnt++;
      if (t >= 2 && t <= 1513) begin
        if (!oVSync) vs_cnt++;
        if (oActive) act_cnt++;
      end
      if (oFrameStart && t <= 1520) begin
        fs_cnt++;
        if (fs1 < 0) fs1 = t;
        else if (fs2 < 0) fs2 = t;
      end
      case (t)
        122:  check("collide_old", px(), 9'o070);
        174:  check("pix_4_3", px(), 0);
        175:  check("pix_5_3", px(), 511);
        176:  check("pix_6_3", px(), 0);
        394:  check("pix_0_7", px(), 511);
        396:  check("pix_2_7", px(), 9'o124);
        409:  check("pix_15_7", px(), 511);
        410:  check("outside_16_7", px(), 0);
        444:  check("blank_50_7", px(), 0);
        1634: check("collide_new", px(), 511);
        default: ;
      endcase
    end
    check("hs_first_fall", 32'(hs_f1), 46);
    check("line_period", 32'(hs_f2 - hs_f1), 56);
    check("hs_width", 32'(hs_cnt), 8);
    check("vs_width", 32'(vs_cnt), 112);
    check("active_count", 32'(act_cnt), 800);
    check("fs_count", 32'(fs_cnt), 2);
    check("fs_first", 32'(fs1), 2);
    check("fs_period", 32'(fs2 - fs1), 1512);

    // Reset mid-frame (raster is inside line 2, visible).
    not_reset = 1'b0;
    iPixEn = 1'b0;
    #2;
    check("midrst_active", 32'(oActive), 0);
    check("midrst_vsync", 32'(oVSync), 1);
    tick();
    not_reset = 1'b1;

    // Half-rate pixel enable.
    hs_f1 = -1; hs_f2 = -1; hs_cnt = 0;
    prev_hs = oHSync;
    for (int t = 1; t <= 360; t++) begin
      iPixEn = (t % 2 == 1);
      tick();
      if (prev_hs && !oHSync) begin
        if (hs_f1 < 0) hs_f1 = t;
        else if (hs_f2 < 0) hs_f2 = t;
      end
      prev_hs = oHSync;
      if (t <= 150 && !oHSync) hs_cnt++;
      case (t)
        346: check("half_pix_4_3", px(), 0);
        347: check("half_pix_5_3a", px(), 511);
        348: check("half_pix_5_3b", px(), 511);
        349: check("half_pix_6_3", px(), 0);
        default: ;
      endcase
    end
    check("half_hs_first_fall", 32'(hs_f1), 89);
    check("half_line_period", 32'(hs_f2 - hs_f1), 112);
    check("half_hs_width", 32'(hs_cnt), 16);

    // Clear sweep with writes attempted to (4,3) while it runs.
    iPixEn = 1'b0;
    iClear = 1'b1;
    tick();
    iClear = 1'b0;
    check("clear_busy_next", 32'(oClearBusy), 32'(CLR));
    busy_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      if (oClearBusy) begin
        busy_cnt++;
        iX = 4'd4; iY = 3'd3; {iR, iG, iB} = 9'o777; iWren = 1'b1;
      end else begin
        iWren = 1'b0;
      end
      tick();
    end
    iWren = 1'b0;
    check("clear_busy_cycles", 32'(busy_cnt), (CLR != 0) ? 128 : 0);

    not_reset = 1'b0;
    tick();
    not_reset = 1'b1;
    iPixEn = 1'b1;
    for (int t = 1; t <= 420; t++) begin
      tick();
      case (t)
        122: check("after_clr_8_2", px(), 32'(FILL));
        174: check("after_clr_4_3", px(), 0);
        175: check("after_clr_5_3", px(), 32'(FILL));
        409: check("after_clr_15_7", px(), 32'(FILL));
        default: ;
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/result_frame_scanout.md
Name: result_frame_scanout

Overview:
- Receiving end of the binarised-result pixel write interface: x, y, 9-bit RGB and write strobe.
- Stores written pixels in an internal 2^WIDTH_BITS x 2^HEIGHT_BITS x 9-bit dual-port frame buffer.
- Independently scans the buffer out as a VGA-style raster (640x480 timing); the image sits in the top-left corner, black elsewhere.
- Sits between the adaptive-threshold top and the board video DAC.

Parameters:
- WIDTH_BITS, 8, image column address width; image width = 2^WIDTH_BITS.
- HEIGHT_BITS, 8, image row address width; image height = 2^HEIGHT_BITS.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 96, horizontal sync width in pixels.
- H_BP, 48, horizontal back porch in pixels.
- V_ACTIVE, 480, visible lines per frame.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vertical sync width in lines.
- V_BP, 33, vertical back porch in lines.

Ports:
- clock  in  1  system clock.
- not_reset  in  1  asynchronous active-low reset.
- iPixEn  in  1  pixel-rate enable; raster advances only on cycles where it is 1.
- iX  in  WIDTH_BITS  write column.
- iY  in  HEIGHT_BITS  write row.
- iR  in  3  write red.
- iG  in  3  write green.
- iB  in  3  write blue.
- iWren  in  1  write strobe, single-cycle, no back-pressure.
- iClear  in  1  clear request (optional feature).
- oClearBusy  out  1  clear sweep in progress.
- oHSync  out  1  horizontal sync, active-low.
- oVSync  out  1  vertical sync, active-low.
- oR  out  3  red to DAC.
- oG  out  3  green to DAC.
- oB  out  3  blue to DAC.
- oActive  out  1  pixel inside the 640x480 visible area.
- oFrameStart  out  1  one-cycle pulse at h=0, v=0.

Behaviour:
- Reset is asynchronous on not_reset (active-low). Values while in reset:
  - hcnt = 0, vcnt = 0.
  - oHSync = 1, oVSync = 1.
  - oR/oG/oB = 0, oActive = 0, oFrameStart = 0, oClearBusy = 0.
  - Frame buffer contents are not reset.
- Write port:
  - On any posedge with iWren=1 (and no clear sweep running), mem[{iY,iX}] <= {iR,iG,iB}.
  - Writes are independent of iPixEn and of raster position.
  - Back-to-back writes are accepted every cycle.
  - A repeated address: last write wins.
- Raster counters:
  - hcnt runs 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800.
  - vcnt runs 0..V_TOTAL-1, where V_TOTAL = 525.
  - Counters advance only when iPixEn=1.
  - hcnt wraps to 0 at H_TOTAL-1 and vcnt increments at that wrap.
  - vcnt wraps to 0 when hcnt and vcnt are both at their maxima.
- Sync decode (on counter values):
  - hsync_n = 0 for H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsync_n = 0 for lines 490..491.
  - active = (hcnt < 640) && (vcnt < 480).
  - inimg = (hcnt < 2^WIDTH_BITS) && (vcnt < 2^HEIGHT_BITS).
- Read pipeline, 2 clock stages:
  - Stage 1: synchronous RAM read at {vcnt[HEIGHT_BITS-1:0], hcnt[WIDTH_BITS-1:0]}; sync/active/inimg/framestart are delayed alongside.
  - Stage 2: registered outputs. oR/oG/oB = RAM data if (active && inimg), else 0.
  - All outputs are aligned; latency from counter value to outputs is exactly 2 clocks regardless of iPixEn.
- Read/write collision on the same address in the same cycle: the read returns the old data.
- oFrameStart: 1 for exactly one clock, 2 clocks after the cycle in which the counters become (0,0) with iPixEn=1.
- iPixEn held at 0: counters freeze and outputs hold their last values (the pipeline still drains).
- Reset mid-frame: the raster restarts at (0,0). Completed memory writes are retained; an in-flight clear sweep is abandoned.

Optional Feature:
- Macro: RESULT_FRAME_CLEAR_EN.
- Defined:
  - A 1-cycle iClear pulse while idle starts a sweep. oClearBusy goes to 1 the next cycle.
  - The sweep writes 0 to addresses 0..2^(WIDTH_BITS+HEIGHT_BITS)-1, one per clock, i.e. 65536 cycles at the defaults.
  - oClearBusy drops to 0 on the cycle after the last address is written.
  - External iWren is ignored while oClearBusy=1, and iClear is ignored while busy.
  - Scan-out continues during the sweep.
- Not defined: iClear is ignored, oClearBusy is tied to 0, and no sweep logic is present.

Test Plan:
- Reset, then iPixEn=1 every cycle -> oHSync low for 96 clocks starting 2 clocks after hcnt=656; line period 800 clocks; oVSync low for 2 lines; oFrameStart every 420000 clocks.
- Write (iX=5, iY=3, RGB=7/7/7), then scan -> oR=oG=oB=7 exactly at the output for h=5, v=3; neighbouring pixels (4,3) and (6,3) = 0 after a clear.
- Write RGB=7 at (255,255) -> output 7 at h=255, v=255; output 0 at h=256 (outside image) and at h=700 (blanking).
- Write addr A=old, then write A=new in the same cycle the raster reads A -> that frame shows old; the next frame shows new.
- iPixEn=1 every 2nd cycle -> line period 1600 clocks; sync widths double; pixel data stays aligned.
- RESULT_FRAME_CLEAR_EN, image filled with 7s, iClear pulse, iWren=1 during the sweep -> oClearBusy high for 65536 cycles; afterwards every pixel reads 0 and the writes made during the sweep are absent.
